// File: rtl/fiat_25519_pkg.sv
// Shared constants, limb-width helpers and state encoding for the
// GF(2^255-19) radix-2^25.5 carry/reduce stream.
package fiat_25519_pkg;

    localparam int FIAT_NUM_LIMBS  = 10;
    localparam int FIAT_FOLD_CONST = 19;

    localparam logic [25:0] MASK_EVEN = 26'h3FF_FFFF;
    localparam logic [25:0] MASK_ODD  = 26'h1FF_FFFF;

    typedef enum logic [1:0] {ACCUM, FOLD, EMIT} state_t;

    // Even limbs carry 26 bits, odd limbs 25 bits.
    function automatic int unsigned limb_width(input logic odd);
        return odd ? 32'd25 : 32'd26;
    endfunction

    function automatic logic [25:0] limb_mask(input logic odd);
        return odd ? MASK_ODD : MASK_EVEN;
    endfunction

endpackage

// File: rtl/fiat_25519_limb_carry.sv
// Combinational split of a signed accumulation into its masked limb and
// arithmetically shifted carry; used by both the ripple and the fold re-carry.
module fiat_25519_limb_carry
    import fiat_25519_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32
) (
    input  logic signed [IN_WIDTH-1:0]  i_x,
    input  logic                        i_odd,
    output logic        [OUT_WIDTH-1:0] o_limb,
    output logic signed [IN_WIDTH-1:0]  o_carry
);

    assign o_limb  = OUT_WIDTH'(i_x[25:0] & limb_mask(i_odd));
    assign o_carry = i_x >>> limb_width(i_odd);

endmodule

// File: rtl/fiat_25519_carry_stream.sv
// Streaming carry/reduce stage: ripples 10 signed accumulations, folds the top
// carry x19 into limb 0, then emits the loosely reduced limbs one per beat.
// Define FIAT_CARRY_OVERLAP_EN for ping-pong banks (emit overlaps next accumulate).
module fiat_25519_carry_stream
    import fiat_25519_pkg::*;
#(
    parameter int IN_WIDTH   = 64,
    parameter int OUT_WIDTH  = 32,
    parameter int NUM_LIMBS  = FIAT_NUM_LIMBS,
    parameter int FOLD_CONST = FIAT_FOLD_CONST
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy
);

`ifdef FIAT_CARRY_OVERLAP_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam logic [3:0] LAST_IDX = 4'(NUM_LIMBS - 1);

    state_t                      r_state;
    logic                        r_live;
    logic [3:0]                  r_a_idx;
    logic [3:0]                  r_e_idx;
    logic                        r_e_valid;
    logic signed [IN_WIDTH-1:0]  r_carry;
    logic [OUT_WIDTH-1:0]        r_buf [NB][NUM_LIMBS];

    logic                        w_a_bank;
    logic                        w_e_bank;
    logic                        w_acc_fire;
    logic                        w_emit_fire;
    logic                        w_emit_done;
    logic                        w_fold_go;
    logic                        w_odd;
    logic signed [IN_WIDTH-1:0]  w_x;
    logic signed [IN_WIDTH-1:0]  w_fold_y;
    logic signed [IN_WIDTH-1:0]  w_cout;
    logic [OUT_WIDTH-1:0]        w_limb;
    logic [OUT_WIDTH-1:0]        w_buf0;
    logic [OUT_WIDTH-1:0]        w_buf1;
    logic [OUT_WIDTH-1:0]        w_emit_data;

`ifdef FIAT_CARRY_OVERLAP_EN
    logic r_a_bank;
    logic r_e_bank;
    assign w_a_bank = r_a_bank;
    assign w_e_bank = r_e_bank;
`else
    assign w_a_bank = 1'b0;
    assign w_e_bank = 1'b0;
`endif

    assign s_ready     = r_live && (r_state == ACCUM);
    assign w_acc_fire  = s_valid && s_ready;
    assign w_emit_fire = r_e_valid && m_ready;
    assign w_emit_done = w_emit_fire && (r_e_idx == LAST_IDX);
    // The fold hands its bank to the emitter, so it waits for the emitter to drain.
    assign w_fold_go   = (r_state == FOLD) && !r_e_valid;

    always_comb begin
        w_buf0      = '0;
        w_buf1      = '0;
        w_emit_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (1'(b) == w_a_bank) begin
                w_buf0 = r_buf[b][0];
                w_buf1 = r_buf[b][1];
            end
            if (1'(b) == w_e_bank)
                w_emit_data = r_buf[b][r_e_idx];
        end
    end

    assign w_fold_y = $signed(IN_WIDTH'(w_buf0)) + r_carry * IN_WIDTH'(FOLD_CONST);
    assign w_x      = (r_state == FOLD) ? w_fold_y : ($signed(s_data) + r_carry);
    assign w_odd    = (r_state == FOLD) ? 1'b0 : r_a_idx[0];

    fiat_25519_limb_carry #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_carry (
        .i_x     (w_x),
        .i_odd   (w_odd),
        .o_limb  (w_limb),
        .o_carry (w_cout)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= ACCUM;
            r_live    <= 1'b0;
            r_a_idx   <= '0;
            r_e_idx   <= '0;
            r_e_valid <= 1'b0;
            r_carry   <= '0;
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < NUM_LIMBS; i++)
                    r_buf[b][i] <= '0;
`ifdef FIAT_CARRY_OVERLAP_EN
            r_a_bank  <= 1'b0;
            r_e_bank  <= 1'b0;
`endif
        end else begin
            r_live <= 1'b1;

            if (w_emit_fire) begin
                r_e_idx <= w_emit_done ? 4'd0 : r_e_idx + 4'd1;
                if (w_emit_done)
                    r_e_valid <= 1'b0;
            end

            case (r_state)
                ACCUM: begin
                    if (w_acc_fire) begin
                        for (int b = 0; b < NB; b++)
                            if (1'(b) == w_a_bank)
                                r_buf[b][r_a_idx] <= w_limb;
                        r_carry <= w_cout;
                        if (r_a_idx == LAST_IDX) begin
                            r_a_idx <= '0;
                            r_state <= FOLD;
                        end else begin
                            r_a_idx <= r_a_idx + 4'd1;
                        end
                    end
                end
                FOLD: begin
                    if (w_fold_go) begin
                        for (int b = 0; b < NB; b++)
                            if (1'(b) == w_a_bank) begin
                                r_buf[b][0] <= w_limb;
                                r_buf[b][1] <= w_buf1 + OUT_WIDTH'(w_cout);
                            end
                        r_carry   <= '0;
                        r_e_valid <= 1'b1;
`ifdef FIAT_CARRY_OVERLAP_EN
                        r_e_bank  <= r_a_bank;
                        r_a_bank  <= ~r_a_bank;
                        r_state   <= ACCUM;
`else
                        r_state   <= EMIT;
`endif
                    end
                end
                EMIT: begin
                    if (w_emit_done)
                        r_state <= ACCUM;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign m_valid = r_e_valid;
    assign m_data  = r_e_valid ? w_emit_data : '0;
    assign m_last  = r_e_valid && (r_e_idx == LAST_IDX);
    assign busy    = (r_state != ACCUM) || (r_a_idx != 4'd0) || r_e_valid;

endmodule

// File: tb/tb_fiat_25519_carry_stream.sv
// Directed bench for fiat_25519_carry_stream: reference carry/fold model,
// scoreboard compare on every output beat, latency/period/reset checks.
module tb_fiat_25519_carry_stream;

    typedef longint          vec_t [10];
    typedef logic [31:0]     res_t [10];
    typedef struct { logic [31:0] data; logic last; } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_hs = 0;
    int          exp_hs = 0;
    int          cyc = 0;
    logic        tog = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    exp_t        exp_q [$];
    int          start_q [$];

    fiat_25519_carry_stream dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    endtask

    task automatic fail_bound(input string nm);
        n_chk++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Reference: ripple with floor-division carries, then x19 fold and one re-carry.
    function automatic void model(input vec_t v, output res_t r);
        longint x, c, y, lim, base;
        c = 0;
        for (int i = 0; i < 10; i++) begin
            base = longint'(1) <<< ((i % 2 == 0) ? 26 : 25);
            x    = v[i] + c;
            lim  = x & (base - 1);
            c    = (x - lim) / base;
            r[i] = 32'(lim);
        end
        base = longint'(1) <<< 26;
        y    = longint'(r[0]) + c * 19;
        lim  = y & (base - 1);
        r[0] = 32'(lim);
        r[1] = 32'(longint'(r[1]) + (y - lim) / base);
    endfunction

    task automatic pin(input string nm, input vec_t v, input res_t want);
        res_t got;
        model(v, got);
        for (int i = 0; i < 10; i++) chk($sformatf("%s_limb%0d", nm, i), got[i], want[i]);
    endtask

    // Called at a negedge; returns at the negedge after the last accepted beat.
    task automatic send(input vec_t v, input int nbeats);
        res_t r;
        int   n;
        for (int i = 0; i < nbeats; i++) begin
            s_valid = 1'b1;
            s_data  = v[i];
            n = 0;
            while (!s_ready) begin
                if (n >= 300) begin
                    fail_bound("s_ready_wait");
                    s_valid = 1'b0;
                    return;
                end
                @(negedge ap_clk);
                n++;
            end
            if (i == 0) start_q.push_back(cyc);
            @(negedge ap_clk);
        end
        s_valid = 1'b0;
        if (nbeats == 10) begin
            model(v, r);
            for (int i = 0; i < 10; i++) exp_q.push_back('{data: r[i], last: (i == 9)});
            exp_hs += 10;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 1000) fail_bound("drain");
    endtask

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_hold = 1'b0;
        end else begin
            m_ready = tog ? ~m_ready : 1'b1;
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    fail_bound("unexpected_output");
                end else begin
                    chk("out_data", m_data, exp_q[0].data);
                    chk("out_last", m_last, exp_q[0].last);
                    if (m_ready) void'(exp_q.pop_front());
                end
                if (m_ready) n_hs++;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
    end

    vec_t v_zero, v_rip, v_neg, v_f9, v_c0, v_nf, v_mix;
    res_t w_zero, w_rip, w_neg, w_f9, w_c0, w_nf;
    int   hs0;
    int   per;

    initial begin
        ap_rst_n = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;

        v_zero = '{default: 0};
        v_rip  = '{default: 0};
        v_neg  = '{default: 0};
        v_f9   = '{default: 0};
        v_c0   = '{default: 0};
        v_nf   = '{default: 0};
        for (int i = 0; i < 10; i++) v_rip[i] = (i % 2 == 0) ? 64'h3FF_FFFF : 64'h1FF_FFFF;
        v_rip[0] = 64'h400_0000;
        v_neg[0] = -1;
        v_f9[9]  = 64'h200_0000;
        v_c0[0]  = 64'h400_0000;
        v_nf[9]  = -64'sh200_0000;
        v_mix = '{64'sh0000_1234_5678_9ABC, -64'sh0000_0ABC_DEF0_1234, 64'sh7_FFFF_FFFF,
                  -64'sh3_0000_0001, 64'sh0123_4567, -64'sh0765_4321, 64'sh0000_0F0F_0F0F_0F0F,
                  64'sh5, -64'sh1_2345_6789, 64'sh0000_00AB_CDEF_0123};

        w_zero = '{default: 0};
        w_rip  = '{default: 0}; w_rip[0] = 32'd19;
        w_f9   = '{default: 0}; w_f9[0]  = 32'd19;
        w_c0   = '{default: 0}; w_c0[1]  = 32'd1;
        w_nf   = '{default: 0}; w_nf[0]  = 32'h3FF_FFED; w_nf[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) w_neg[i] = (i % 2 == 0) ? 32'h3FF_FFFF : 32'h1FF_FFFF;
        w_neg[0] = 32'h3FF_FFEC;

        pin("pin_zero", v_zero, w_zero);
        pin("pin_ripple", v_rip, w_rip);
        pin("pin_neg", v_neg, w_neg);
        pin("pin_fold9", v_f9, w_f9);
        pin("pin_carry0", v_c0, w_c0);
        pin("pin_negfold", v_nf, w_nf);

        #22;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", busy, 1'b0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1 chk("s_ready_after_deassert", s_ready, 1'b0);
        @(negedge ap_clk);
        chk("s_ready_first_clock", s_ready, 1'b1);

        send(v_zero, 10);
        chk("lat_fold_cycle_no_valid", m_valid, 1'b0);
        chk("lat_fold_cycle_busy", busy, 1'b1);
        @(negedge ap_clk);
        chk("lat_valid_2_cycles", m_valid, 1'b1);
        drain();

        send(v_rip, 10);  drain();
        send(v_neg, 10);  drain();
        send(v_f9, 10);   drain();
        send(v_c0, 10);   drain();
        send(v_nf, 10);   drain();
        chk("idle_after_drain", busy, 1'b0);

        tog = 1'b1;
        hs0 = n_hs;
        send(v_mix, 10);
        drain();
        chk("bp_handshakes", 64'(n_hs - hs0), 64'd10);
        tog = 1'b0;
        @(negedge ap_clk);

        send(v_mix, 5);
        chk("partial_busy", busy, 1'b1);
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_m_data", m_data, 32'd0);
        chk("midrst_s_ready", s_ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        send(v_rip, 10);
        drain();

`ifdef FIAT_CARRY_OVERLAP_EN
        per = 11;
`else
        per = 21;
`endif
        start_q.delete();
        send(v_rip, 10);
        send(v_neg, 10);
        send(v_mix, 10);
        drain();
        chk("period_1", 64'(start_q[1] - start_q[0]), 64'(per));
        chk("period_2", 64'(start_q[2] - start_q[1]), 64'(per));

`ifdef FIAT_CARRY_OVERLAP_EN
        tog = 1'b1;
        send(v_mix, 10);
        send(v_nf, 10);
        send(v_c0, 10);
        drain();
        tog = 1'b0;
`endif

        @(negedge ap_clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("handshake_total", 64'(n_hs), 64'(exp_hs));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fiat_25519_carry_stream.md
Name: fiat_25519_carry_stream

Overview:
- Streaming carry/reduce stage for GF(2^255-19) in 10-limb radix-2^25.5 form, on the consumer side of the limb multipliers.
- Accepts 10 wide signed partial-product accumulations, one per beat.
- Ripples carries limb 0→9 (26/25/26/... bit masks), folds the final carry back into limb 0 via ×19, and re-carries into limb 1.
- Buffers the 10 reduced limbs and emits them one per beat under valid/ready.

Parameters:
- IN_WIDTH, 64, signed accumulator width per input limb.
- OUT_WIDTH, 32, output limb width; values are unsigned and zero-extended.
- NUM_LIMBS, 10, limbs per field element; only 10 is supported.
- FOLD_CONST, 19, constant multiplied into the folded carry; 7-bit unsigned.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready.
- s_data  in  IN_WIDTH  signed accumulation for the current limb index.
- m_valid  out  1  output limb valid.
- m_ready  in  1  downstream accepts.
- m_data  out  OUT_WIDTH  reduced limb.
- m_last  out  1  high with limb 9.
- busy  out  1  high in any state other than ACCUM with idx==0.

Behaviour:
- Reset (ap_rst_n=0, asynchronous): state=ACCUM, idx=0, carry=0, limb buffer cleared, s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0. s_ready rises on the first clock after deassertion.
- Reset asserted mid-element discards the partial element; no output is produced for it.
- State ACCUM (s_ready=1):
  - On each accepted beat: x = s_data + carry (IN_WIDTH signed).
  - w = 26 if idx is even, else 25.
  - buf[idx] = x[w-1:0], zero-extended to OUT_WIDTH.
  - carry = x >>> w (arithmetic shift).
  - idx++.
  - The beat with idx==9 moves to FOLD, with idx cleared.
- State FOLD (one cycle, s_ready=0):
  - y = buf[0] + carry*FOLD_CONST (signed, IN_WIDTH).
  - buf[0] = y[25:0].
  - buf[1] = buf[1] + (y>>>26), truncated to OUT_WIDTH.
  - carry=0. Next state is EMIT.
- State EMIT:
  - m_valid=1, m_data=buf[idx], m_last=(idx==9).
  - idx advances only on m_valid&&m_ready.
  - The handshake at idx==9 moves to ACCUM with idx=0.
  - m_data/m_last hold stable while m_ready=0.
- Latency: first output limb is valid 2 cycles after the 10th input beat is accepted. With m_ready held high, element period is 21 cycles.
- Negative inputs:
  - Masking yields non-negative limbs.
  - A negative carry propagates; a negative fold subtracts from limb 0.
  - Limb 1 may exceed 25 bits only by the fold carry. No further reduction is performed; the output is loosely reduced.
- No overflow detection. Inputs are bounded by the multiplier stage so that |carry*19| < 2^(IN_WIDTH-1).
- s_valid is ignored outside ACCUM. m_ready is ignored outside EMIT.

Optional Feature:
- Macro FIAT_CARRY_OVERLAP_EN.
- Defined:
  - Two limb buffers, ping-pong.
  - After FOLD, EMIT runs from the folded bank while ACCUM concurrently fills the other bank (s_ready=1 during EMIT).
  - If ACCUM completes a new element before EMIT finishes, s_ready drops and the FOLD of the new element waits until the old EMIT completes.
  - Sustained period is 11 cycles per element.
  - busy = either bank non-idle.
- Undefined: single buffer, strictly sequential as above.

Decomposition:
- Shared package fiat_25519_pkg holds:
  - NUM_LIMBS, FOLD_CONST.
  - Limb width function (26 for even index, 25 for odd) and the mask constants.
  - State enum {ACCUM, FOLD, EMIT}.
- One natural sub-module: fiat_25519_limb_carry, purely combinational. Takes (x, idx parity) and returns (masked limb, shifted carry). It is shared by ACCUM and by the FOLD re-carry.

Test Plan:
- All 10 inputs 0 → 10 outputs 0, m_last on the 10th, m_valid 2 cycles after the last input.
- Carry ripple:
  - Input: limb0=0x4000000, limb1=0x1FFFFFF, limb2=0x3FFFFFF, ... alternating full masks through limb9=0x1FFFFFF.
  - Required output: limb0=19, limbs1..9=0 (ripple carry out of limb 9 folded ×19).
- Negative wrap:
  - Input: limb0=-1, rest 0.
  - Required output: limb0=0x3FFFFEC, odd limbs=0x1FFFFFF, even limbs 2..8=0x3FFFFFF (p-1).
- Simple fold and carry:
  - Input: limb9=0x2000000 (others 0) → limb0=19, rest 0.
  - Input: limb0=0x4000000 → limb1=1, rest 0.
- Backpressure and reset:
  - m_ready toggled 1-0-1 each cycle → data held stable while m_ready=0, exactly 10 handshakes, 0 lost or duplicated.
  - ap_rst_n pulsed low after 5 input beats → outputs drop to 0 immediately; the next full element is processed correctly.
- With FIAT_CARRY_OVERLAP_EN: 3 back-to-back elements with m_ready=1 → outputs in order, 11-cycle element period, no s_ready stall except when the full-bank condition is forced.
